// File: rtl/lsu_rv32i.sv
// lsu_rv32i: single-outstanding RV32I load/store unit in front of data_mem_rv32i.
// Optional feature: define LSU_MISALIGN_TRAP_EN to trap misaligned accesses in the LSU;
// when undefined, misaligned requests go to memory unchanged and the memory decides.
module lsu_rv32i (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_is_load,
  input  logic        in_is_store,
  input  logic [2:0]  in_funct3,
  input  logic [31:0] in_addr,
  input  logic [31:0] in_wdata,
  input  logic [4:0]  in_rd,
  output logic        mem_we,
  output logic        mem_re,
  output logic [2:0]  mem_width_sel,
  output logic [8:0]  mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_is_load,
  output logic [4:0]  out_rd,
  output logic [31:0] out_data,
  output logic        exc_misaligned,
  output logic        exc_fault,
  output logic        exc_illegal
);

  typedef enum logic [1:0] {IDLE, ACCESS, CAPTURE, RESP} state_t;

  state_t      state_q, state_d;
  logic [8:0]  addr_q;
  logic [31:0] wdata_q;
  logic [2:0]  width_q;
  logic        is_load_q;
  logic [4:0]  rd_q;
  logic [31:0] data_q;
  logic        out_is_load_q;
  logic        exc_m_q, exc_f_q, exc_i_q;

  logic        accept;
  logic        f3_ok;
  logic [2:0]  width_d;
  logic        illegal;
  logic        misaligned;
  logic        fault;
  logic        any_exc;

  assign in_ready = (state_q == IDLE) & ~rst;
  assign accept   = in_valid & in_ready;

  // Decode funct3 into the memory width code and detect illegal requests
  always_comb begin
    width_d = in_funct3;
    f3_ok   = 1'b0;
    if (in_is_load) begin
      unique case (in_funct3)
        3'b000:  begin width_d = 3'b000; f3_ok = 1'b1; end
        3'b001:  begin width_d = 3'b001; f3_ok = 1'b1; end
        3'b010:  begin width_d = 3'b010; f3_ok = 1'b1; end
        3'b100:  begin width_d = 3'b011; f3_ok = 1'b1; end
        3'b101:  begin width_d = 3'b100; f3_ok = 1'b1; end
        default: begin width_d = in_funct3; f3_ok = 1'b0; end
      endcase
    end else begin
      f3_ok = (in_funct3 == 3'b000) | (in_funct3 == 3'b001) | (in_funct3 == 3'b010);
    end
    illegal = (in_is_load == in_is_store) | ~f3_ok;
  end

`ifdef LSU_MISALIGN_TRAP_EN
  assign misaligned = ~illegal &
                      (((in_funct3[1:0] == 2'b01) & in_addr[0]) |
                       ((in_funct3[1:0] == 2'b10) & (in_addr[1:0] != 2'b00)));
`else
  assign misaligned = 1'b0;
`endif

  // Exceptions are mutually exclusive: illegal beats misaligned beats fault
  assign fault   = ~illegal & ~misaligned & (in_addr[31:9] != '0);
  assign any_exc = illegal | misaligned | fault;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic: exceptions skip memory, stores skip capture
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = any_exc ? RESP : ACCESS;
      ACCESS:  state_d = is_load_q ? CAPTURE : RESP;
      CAPTURE: state_d = RESP;
      RESP:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Request capture on accept and load-data capture one cycle after the memory read
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q        <= '0;
      wdata_q       <= '0;
      width_q       <= '0;
      is_load_q     <= 1'b0;
      rd_q          <= '0;
      data_q        <= '0;
      out_is_load_q <= 1'b0;
      exc_m_q       <= 1'b0;
      exc_f_q       <= 1'b0;
      exc_i_q       <= 1'b0;
    end else if (accept) begin
      addr_q        <= in_addr[8:0];
      wdata_q       <= in_wdata;
      width_q       <= width_d;
      is_load_q     <= in_is_load;
      rd_q          <= in_rd;
      data_q        <= '0;
      out_is_load_q <= in_is_load & ~any_exc;
      exc_m_q       <= misaligned;
      exc_f_q       <= fault;
      exc_i_q       <= illegal;
    end else if (state_q == CAPTURE) begin
      data_q        <= mem_rdata;
    end
  end

  // Memory strobes only in ACCESS, and never while reset is asserted
  assign mem_re        = (state_q == ACCESS) & is_load_q & ~rst;
  assign mem_we        = (state_q == ACCESS) & ~is_load_q & ~rst;
  assign mem_addr      = addr_q;
  assign mem_width_sel = width_q;
  assign mem_wdata     = wdata_q;

  assign out_valid      = (state_q == RESP);
  assign out_is_load    = out_is_load_q;
  assign out_rd         = rd_q;
  assign out_data       = data_q;
  assign exc_misaligned = exc_m_q;
  assign exc_fault      = exc_f_q;
  assign exc_illegal    = exc_i_q;

endmodule

// File: tb/tb_lsu_rv32i.sv
// tb_lsu_rv32i: scoreboard bench for lsu_rv32i with a byte-array memory and reference model.
module tb_lsu_rv32i;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        in_is_load = 1'b0;
  logic        in_is_store = 1'b0;
  logic [2:0]  in_funct3 = '0;
  logic [31:0] in_addr = '0;
  logic [31:0] in_wdata = '0;
  logic [4:0]  in_rd = '0;
  logic        mem_we, mem_re;
  logic [2:0]  mem_width_sel;
  logic [8:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        out_is_load;
  logic [4:0]  out_rd;
  logic [31:0] out_data;
  logic        exc_misaligned, exc_fault, exc_illegal;

  always #5 clk = ~clk;

  lsu_rv32i dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_is_load(in_is_load),
    .in_is_store(in_is_store), .in_funct3(in_funct3), .in_addr(in_addr),
    .in_wdata(in_wdata), .in_rd(in_rd),
    .mem_we(mem_we), .mem_re(mem_re), .mem_width_sel(mem_width_sel),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_is_load(out_is_load),
    .out_rd(out_rd), .out_data(out_data), .exc_misaligned(exc_misaligned),
    .exc_fault(exc_fault), .exc_illegal(exc_illegal)
  );

  typedef struct {
    logic        is_load;
    logic [4:0]  rd;
    logic [31:0] data;
    logic        em, ef, ei;
    int          lat;
    int          acc;
    logic [2:0]  width;
    int          acc_base;
    int          acc_cyc;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;
  int unsigned cyc = 0;
  int acc_cnt = 0;
  logic [2:0] acc_width = '0;
  int stall = 0;
  int last_vcyc = 0;

  logic [7:0] mem  [0:511];
  logic [7:0] rmem [0:511];
  bit mem_init = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- memory responder (data_mem_rv32i behaviour) ----------------
  function automatic bit mem_misal(input logic [8:0] a, input logic [2:0] w);
    if (w == 3'd1 || w == 3'd4) return a[0];
    if (w == 3'd2) return a[1:0] != 2'b00;
    return 0;
  endfunction

  function automatic logic [31:0] mem_rd(input logic [8:0] a, input logic [2:0] w);
    logic [7:0]  b0, b1;
    if (mem_misal(a, w)) return '0;
    b0 = mem[a];
    case (w)
      3'd0: return {{24{b0[7]}}, b0};
      3'd3: return {24'd0, b0};
      3'd1: begin b1 = mem[a + 9'd1]; return {{16{b1[7]}}, b1, b0}; end
      3'd4: begin b1 = mem[a + 9'd1]; return {16'd0, mem[a + 9'd1], b0}; end
      3'd2: return {mem[a + 9'd3], mem[a + 9'd2], mem[a + 9'd1], b0};
      default: return '0;
    endcase
  endfunction

  always @(posedge clk) begin
    if (rst && !mem_init) begin
      for (int i = 0; i < 512; i++) mem[i] <= rmem[i];
      mem_init <= 1;
    end
    if (mem_re || mem_we) begin
      acc_cnt   <= acc_cnt + 1;
      acc_width <= mem_width_sel;
    end
    if (mem_re) mem_rdata <= mem_rd(mem_addr, mem_width_sel);
    if (mem_we && !mem_misal(mem_addr, mem_width_sel)) begin
      case (mem_width_sel)
        3'd0: mem[mem_addr] <= mem_wdata[7:0];
        3'd1: begin
          mem[mem_addr]        <= mem_wdata[7:0];
          mem[mem_addr + 9'd1] <= mem_wdata[15:8];
        end
        3'd2: begin
          mem[mem_addr]        <= mem_wdata[7:0];
          mem[mem_addr + 9'd1] <= mem_wdata[15:8];
          mem[mem_addr + 9'd2] <= mem_wdata[23:16];
          mem[mem_addr + 9'd3] <= mem_wdata[31:24];
        end
        default: ;
      endcase
    end
  end

  // ---------------- reference model ----------------
  function automatic logic [31:0] ref_load(input int addr, input int size, input bit sgn);
    longint v = 0;
    for (int i = 0; i < size; i++) v += longint'(rmem[addr + i]) << (8 * i);
    if (sgn && v >= (longint'(1) << (8 * size - 1))) v -= longint'(1) << (8 * size);
    return v[31:0];
  endfunction

  function automatic exp_t model(input logic ld, input logic st, input logic [2:0] f3,
                                 input logic [31:0] addr, input logic [4:0] rd);
    exp_t e;
    bit   legal;
    bit   mis;
    int   size;
    e = '{default: 0};
    e.rd = rd;
    if (ld && !st)      legal = (f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5);
    else if (st && !ld) legal = (f3 <= 2);
    else                legal = 0;
    size = 1 << f3[1:0];
    mis  = (addr % size) != 0;
    if (!legal) e.ei = 1;
`ifdef LSU_MISALIGN_TRAP_EN
    else if (mis) e.em = 1;
`endif
    else if (addr > 511) e.ef = 1;
    else begin
      e.acc = 1;
      e.is_load = ld;
      if (ld) begin
        e.width = (f3 == 4) ? 3'd3 : (f3 == 5) ? 3'd4 : f3;
        if (!mis) e.data = ref_load(int'(addr), size, !f3[2]);
      end else begin
        e.width = f3;
      end
    end
    e.lat = !e.acc ? 1 : (ld ? 3 : 2);
    return e;
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic issue(input logic ld, input logic st, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wd, input logic [4:0] rd);
    exp_t e;
    int   n = 0;
    e = model(ld, st, f3, addr, rd);
    @(posedge clk); #1;
    in_valid = 1; in_is_load = ld; in_is_store = st; in_funct3 = f3;
    in_addr = addr; in_wdata = wd; in_rd = rd;
    @(negedge clk);
    while (!in_ready && n < 50) begin n++; @(negedge clk); end
    if (!in_ready) begin
      checks++; errors++;
      $display("FAIL accept_timeout: in_ready stayed 0, required 1");
      in_valid = 0;
      return;
    end
    @(posedge clk); #1;
    in_valid = 0;
    e.acc_cyc  = cyc;
    e.acc_base = acc_cnt;
    if (st && !ld && e.acc && (addr % (1 << f3[1:0])) == 0)
      for (int i = 0; i < (1 << f3[1:0]); i++) rmem[addr + i] = wd[8 * i +: 8];
    q.push_back(e);
  endtask

  task automatic wait_done();
    int n = 0;
    while (q.size() > 0 && n < 100) begin n++; @(negedge clk); end
    if (q.size() > 0) begin
      checks++; errors++;
      $display("FAIL resp_timeout: %0d responses outstanding, required 0", q.size());
      q.delete();
    end
    @(negedge clk);
  endtask

  task automatic run(input logic ld, input logic st, input logic [2:0] f3,
                     input logic [31:0] addr, input logic [31:0] wd, input logic [4:0] rd);
    issue(ld, st, f3, addr, wd, rd);
    wait_done();
  endtask

  // ---------------- writeback-side ready driver ----------------
  initial begin
    forever begin
      @(posedge clk); #1;
      if (stall > 0) begin
        out_ready = 0;
        if (out_valid) stall--;
      end else begin
        out_ready = ($urandom_range(0, 3) != 0);
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  initial begin
    exp_t        e;
    bit          prev_v = 0;
    bit          popped = 0;
    int          vcyc = 0;
    logic [31:0] snap_data;
    logic [8:0]  snap_ctl;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_v = 0; popped = 0; vcyc = 0;
      end else begin
        if (popped) begin
          chk("valid_clear_after_handshake", out_valid, 0);
          popped = 0;
        end
        if (out_valid) begin
          if (!prev_v) begin
            vcyc = 0;
            snap_data = out_data;
            snap_ctl  = {out_is_load, out_rd, exc_misaligned, exc_fault, exc_illegal};
            if (q.size() == 0) begin
              checks++; errors++;
              $display("FAIL unexpected_resp: out_valid 1 with no request outstanding, required 0");
            end else begin
              chk("latency_cycle", cyc, q[0].acc_cyc + q[0].lat - 1);
            end
          end else begin
            chk("hold_out_data", out_data, snap_data);
            chk("hold_out_ctl", {out_is_load, out_rd, exc_misaligned, exc_fault, exc_illegal}, snap_ctl);
          end
          chk("in_ready_busy", in_ready, 0);
          vcyc++;
          if (out_ready && q.size() > 0) begin
            e = q.pop_front();
            chk("out_data", out_data, e.data);
            chk("out_rd", out_rd, e.rd);
            chk("out_is_load", out_is_load, e.is_load);
            chk("exc_misaligned", exc_misaligned, e.em);
            chk("exc_fault", exc_fault, e.ef);
            chk("exc_illegal", exc_illegal, e.ei);
            chk("mem_access_count", acc_cnt - e.acc_base, e.acc);
            if (e.acc) chk("mem_width_sel", acc_width, e.width);
            last_vcyc = vcyc;
            popped = 1;
          end
        end
        prev_v = out_valid;
      end
    end
  end

  // ---------------- main sequence ----------------
  initial begin
    logic [2:0]  f3;
    logic [31:0] a;
    logic        ld, st;
    int          r;
    for (int i = 0; i < 512; i++) rmem[i] = 8'($urandom_range(0, 255));
    rst = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_mem_strobes", {mem_re, mem_we}, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_exc", {exc_misaligned, exc_fault, exc_illegal}, 0);
    @(posedge clk); #1;
    rst = 0;
    @(negedge clk);
    chk("idle_in_ready", in_ready, 1);

    // store then load back
    run(0, 1, 3'b010, 32'h010, 32'hA5A5_0010, 5'd5);
    run(1, 0, 3'b010, 32'h010, 32'h0, 5'd7);
    // sub-word loads with sign/zero extension
    run(0, 1, 3'b010, 32'h00C, 32'h80FF_7F01, 5'd1);
    run(1, 0, 3'b000, 32'h00D, 32'h0, 5'd2);
    run(1, 0, 3'b100, 32'h00D, 32'h0, 5'd3);
    run(1, 0, 3'b001, 32'h00E, 32'h0, 5'd4);
    run(1, 0, 3'b101, 32'h00E, 32'h0, 5'd6);
    // misaligned, fault, illegal
    run(1, 0, 3'b010, 32'h002, 32'h0, 5'd8);
    run(1, 0, 3'b010, 32'h200, 32'h0, 5'd9);
    run(1, 0, 3'b011, 32'h000, 32'h0, 5'd10);
    run(1, 1, 3'b010, 32'h000, 32'h0, 5'd11);
    run(0, 0, 3'b000, 32'h000, 32'h0, 5'd12);
    // writeback back-pressure for five response cycles
    stall = 5;
    run(1, 0, 3'b010, 32'h010, 32'h0, 5'd13);
    chk("stall_resp_cycles_ge6", (last_vcyc >= 6) ? 1 : 0, 1);
    stall = 0;

    // reset while a store sits in ACCESS: no write, no response
    @(posedge clk); #1;
    in_valid = 1; in_is_load = 0; in_is_store = 1; in_funct3 = 3'b010;
    in_addr = 32'h004; in_wdata = 32'h1234_5678; in_rd = 5'd14;
    @(negedge clk);
    chk("abort_accept_ready", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 0;
    rst = 1;
    @(negedge clk);
    chk("abort_mem_we", mem_we, 0);
    chk("abort_in_ready", in_ready, 0);
    @(posedge clk); #1;
    rst = 0;
    repeat (4) @(negedge clk);
    chk("abort_no_valid", out_valid, 0);
    run(1, 0, 3'b010, 32'h004, 32'h0, 5'd15);

    // randomized traffic
    for (int n = 0; n < 150; n++) begin
      r = $urandom_range(0, 19);
      ld = (r % 2 == 0); st = !ld;
      if (r == 0) begin ld = 1; st = 1; end
      if (r == 1) begin ld = 0; st = 0; end
      f3 = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 3) != 0) f3 = ld ? 3'($urandom_range(0, 2) + (($urandom_range(0, 1) == 1) ? 0 : 0)) : 3'($urandom_range(0, 2));
      if (ld && $urandom_range(0, 3) == 0) f3 = 3'($urandom_range(4, 5));
      a = 32'($urandom_range(0, 63));
      if ($urandom_range(0, 9) == 0) a = $urandom | 32'h200;
      run(ld, st, f3, a, $urandom, 5'($urandom_range(0, 31)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, errors so far %0d", errors);
    $fatal(1, "timeout");
  end

endmodule
